// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package serial_add_sub_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int width);
    int n;
    n = $clog2(width / NIBBLE_W);
    return (n < 1) ? 1 : n;
  endfunction
endpackage

// File: rtl/serial_add_sub_ctrl_slice.sv
// 4-bit ripple add/sub slice built from an array of full adders.
// The m input inverts b for subtraction; ci is separate so carries can chain across nibbles.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_add_slice
  import serial_add_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);
  logic [NIBBLE_W:0]   c;
  logic [NIBBLE_W-1:0] bx;

  assign c[0] = ci;
  assign bx   = b ^ {NIBBLE_W{m}};

  full_adder u_fa [NIBBLE_W-1:0] (
    .a  (a),
    .b  (bx),
    .ci (c[NIBBLE_W-1:0]),
    .s  (s),
    .co (c[NIBBLE_W:1])
  );

  assign co = c[NIBBLE_W];
  assign c3 = c[NIBBLE_W-1];
endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Multi-precision A+/-B sequencer: one nibble per cycle through a single slice, LSB first.
// Optional macro SERIAL_ADD_SUB_SATURATE_EN clamps overflowing results to the signed limit.
module serial_add_sub_ctrl
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("serial_add_sub_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q;
  logic [NIB-1:0][NIBBLE_W-1:0] a_q, b_q, res_q, res_nxt, res_fin;
  logic                         sub_q, cy_q, carry_q, ovf_q, zero_q;
  logic [NIBBLE_W-1:0]          s;
  logic                         co, c3, last, ovf_nxt;

  nibble_add_slice u_slice (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .m  (sub_q),
    .ci (cy_q),
    .s  (s),
    .co (co),
    .c3 (c3)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last           = (cnt_q == LAST);
    ovf_nxt        = co ^ c3;
    res_nxt        = res_q;
    res_nxt[cnt_q] = s;
    res_fin        = res_nxt;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    // Clamp direction follows the sign of A: an overflow always matches A's sign.
    if (ovf_nxt)
      res_fin = a_q[NIB-1][NIBBLE_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          sub_q <= sub;
          cy_q  <= sub;  // +1 of the two's-complement negate enters as carry-in
          cnt_q <= '0;
        end
        RUN: begin
          cy_q  <= co;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            res_q   <= res_fin;
            carry_q <= co;
            ovf_q   <= ovf_nxt;
            zero_q  <= (res_fin == '0);
          end else begin
            res_q   <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl at WIDTH=16; honours SERIAL_ADD_SUB_SATURATE_EN.
module tb_serial_add_sub_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        carry, overflow, zero;
  int          checks = 0;
  int          passed = 0;

  serial_add_sub_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Present operands for one accept edge, then scramble inputs and count edges to out_valid.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        output int lat);
    @(negedge clk); a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; a = ~av; b = ~bv; sub = ~sv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs got %b want 10", {in_ready, out_valid}); else passed++;
    checks++; if ({result, carry, overflow, zero} !== 19'h0) $display("FAIL reset_out got %h want 0", {result, carry, overflow, zero}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h1234, 16'h0FF1, 1'b0, lat);
    checks++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else passed++;
    checks++; if ({result, carry, overflow, zero} !== {16'h2225, 3'b000}) $display("FAIL add_basic got %h c%b v%b z%b want 2225 000", result, carry, overflow, zero); else passed++;
    consume();
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if ({result, carry, overflow, zero} !== {16'h0000, 3'b101}) $display("FAIL add_wrap got %h c%b v%b z%b want 0000 101", result, carry, overflow, zero); else passed++;
    consume();
  endtask

  task automatic test_sub();
    int lat;
    run_op(16'h0005, 16'h0007, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL sub_latency got %0d want 4", lat); else passed++;
    checks++; if ({result, carry, overflow, zero} !== {16'hFFFE, 3'b000}) $display("FAIL sub_borrow got %h c%b v%b z%b want fffe 000", result, carry, overflow, zero); else passed++;
    consume();
    run_op(16'h1234, 16'h1234, 1'b1, lat);
    checks++; if ({result, carry, overflow, zero} !== {16'h0000, 3'b101}) $display("FAIL sub_zero got %h c%b v%b z%b want 0000 101", result, carry, overflow, zero); else passed++;
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    logic [15:0] exp_pos, exp_neg;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if ({result, carry, overflow, zero} !== {exp_pos, 3'b010}) $display("FAIL ovf_add got %h c%b v%b z%b want %h 010", result, carry, overflow, zero, exp_pos); else passed++;
    consume();
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    checks++; if ({result, carry, overflow, zero} !== {exp_neg, 3'b110}) $display("FAIL ovf_sub got %h c%b v%b z%b want %h 110", result, carry, overflow, zero, exp_neg); else passed++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h0100, 16'h0200, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, in_ready, result} !== {2'b10, 16'h0300}) $display("FAIL bp_hold cyc%0d got v%b r%b %h want v1 r0 0300", i, out_valid, in_ready, result); else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got r%b v%b want r1 v0", in_ready, out_valid); else passed++;
    run_op(16'h0003, 16'h0004, 1'b0, lat);
    checks++; if ({lat, result} !== {32'd4, 16'h0007}) $display("FAIL bp_second got lat %0d %h want 4 0007", lat, result); else passed++;
    consume();
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk); a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++; if ({in_ready, out_valid, result} !== {2'b10, 16'h0000}) $display("FAIL mid_reset got r%b v%b %h want r1 v0 0000", in_ready, out_valid, result); else passed++;
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    checks++; if ({lat, result, carry, overflow, zero} !== {32'd4, 16'h0002, 3'b000}) $display("FAIL post_reset_add got lat %0d %h c%b v%b z%b want 4 0002 000", lat, result, carry, overflow, zero); else passed++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
